// File: rtl/txsettings_pkg.sv
// Shared definitions for the transmit-settings controller: FSM encoding and
// the Miller/FM0 select values carried in m_in/m_out.
package txsettings_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    localparam logic [1:0] M_FM0 = 2'd0;
    localparam logic [1:0] M_M2  = 2'd1;
    localparam logic [1:0] M_M4  = 2'd2;
    localparam logic [1:0] M_M8  = 2'd3;

endpackage

// File: rtl/txsettings_ctrl.sv
// Double-buffered transmit settings: an accepted Query lands in a shadow copy
// and is moved to the active outputs only while the transmitter is idle.
module txsettings_ctrl
    import txsettings_pkg::*;
#(
    parameter int TRCAL_W   = 10,
    parameter int TRCAL_MIN = 16,
    parameter int TRCAL_MAX = 1000,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [TRCAL_W-1:0] trcal_in,
    input  logic [1:0]         m_in,
    input  logic               dr_in,
    input  logic               trext_in,
    input  logic               querycomplete,
    input  logic               tx_busy,
    output logic [TRCAL_W-1:0] trcal_out,
    output logic [1:0]         m_out,
    output logic               dr_out,
    output logic               trext_out,
    output logic               settings_valid,
    output logic               update_pending,
    output logic               applied,
    output logic               rejected,
    output logic [CNT_W-1:0]   update_count,
    output logic [1:0]         state_dbg
);

    localparam logic [TRCAL_W-1:0] TRCAL_LO = TRCAL_W'(TRCAL_MIN);
    localparam logic [TRCAL_W-1:0] TRCAL_HI = TRCAL_W'(TRCAL_MAX);

    state_e             state_q, state_d;
    logic               qc_prev_q, qc_prev_d;
    logic [TRCAL_W-1:0] sh_trcal_q, sh_trcal_d;
    logic [1:0]         sh_m_q, sh_m_d;
    logic               sh_dr_q, sh_dr_d;
    logic               sh_trext_q, sh_trext_d;
    logic [TRCAL_W-1:0] act_trcal_q, act_trcal_d;
    logic [1:0]         act_m_q, act_m_d;
    logic               act_dr_q, act_dr_d;
    logic               act_trext_q, act_trext_d;
    logic               valid_q, valid_d;
    logic               applied_q, applied_d;
    logic               rejected_q, rejected_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic qc_edge;
    logic in_range;
    logic do_apply;

    assign qc_edge  = querycomplete && !qc_prev_q;
    assign in_range = (trcal_in >= TRCAL_LO) && (trcal_in <= TRCAL_HI);
    assign do_apply = (state_q == ST_PENDING) && !tx_busy;

    always_comb begin
        state_d     = state_q;
        qc_prev_d   = querycomplete;
        sh_trcal_d  = sh_trcal_q;
        sh_m_d      = sh_m_q;
        sh_dr_d     = sh_dr_q;
        sh_trext_d  = sh_trext_q;
        act_trcal_d = act_trcal_q;
        act_m_d     = act_m_q;
        act_dr_d    = act_dr_q;
        act_trext_d = act_trext_q;
        valid_d     = valid_q;
        count_d     = count_q;
        applied_d   = 1'b0;
        rejected_d  = 1'b0;

        if (do_apply) begin
            act_trcal_d = sh_trcal_q;
            act_m_d     = sh_m_q;
            act_dr_d    = sh_dr_q;
            act_trext_d = sh_trext_q;
            valid_d     = 1'b1;
            applied_d   = 1'b1;
            state_d     = ST_ACTIVE;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // A new Query arriving in the apply cycle overrides the ACTIVE move above.
        if (qc_edge) begin
            if (in_range) begin
                sh_trcal_d = trcal_in;
                sh_m_d     = m_in;
                sh_dr_d    = dr_in;
                sh_trext_d = trext_in;
                state_d    = ST_PENDING;
            end else begin
                rejected_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            qc_prev_q   <= 1'b0;
            sh_trcal_q  <= '0;
            sh_m_q      <= '0;
            sh_dr_q     <= 1'b0;
            sh_trext_q  <= 1'b0;
            act_trcal_q <= '0;
            act_m_q     <= '0;
            act_dr_q    <= 1'b0;
            act_trext_q <= 1'b0;
            valid_q     <= 1'b0;
            applied_q   <= 1'b0;
            rejected_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            qc_prev_q   <= qc_prev_d;
            sh_trcal_q  <= sh_trcal_d;
            sh_m_q      <= sh_m_d;
            sh_dr_q     <= sh_dr_d;
            sh_trext_q  <= sh_trext_d;
            act_trcal_q <= act_trcal_d;
            act_m_q     <= act_m_d;
            act_dr_q    <= act_dr_d;
            act_trext_q <= act_trext_d;
            valid_q     <= valid_d;
            applied_q   <= applied_d;
            rejected_q  <= rejected_d;
            count_q     <= count_d;
        end
    end

    assign trcal_out      = act_trcal_q;
    assign m_out          = act_m_q;
    assign dr_out         = act_dr_q;
    assign trext_out      = act_trext_q;
    assign settings_valid = valid_q;
    assign update_pending = (state_q == ST_PENDING);
    assign applied        = applied_q;
    assign rejected       = rejected_q;
    assign update_count   = count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_txsettings_ctrl.sv
// Directed bench for txsettings_ctrl: expected applied settings are queued as
// Queries are issued and a negedge monitor checks each applied/rejected pulse.
module tb_txsettings_ctrl;
    import txsettings_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [9:0] trcal_in;
    logic [1:0] m_in;
    logic       dr_in;
    logic       trext_in;
    logic       querycomplete;
    logic       tx_busy;
    logic [9:0] trcal_out;
    logic [1:0] m_out;
    logic       dr_out;
    logic       trext_out;
    logic       settings_valid;
    logic       update_pending;
    logic       applied;
    logic       rejected;
    logic [7:0] update_count;
    logic [1:0] state_dbg;

    logic [9:0] trcal2_in;
    logic       qc2;
    logic [9:0] trcal2_out;
    logic [1:0] m2_out;
    logic       dr2_out;
    logic       trext2_out;
    logic       valid2;
    logic       pending2;
    logic       applied2;
    logic       rejected2;
    logic [1:0] count2;
    logic [1:0] state2_dbg;

    int checks = 0;
    int errors = 0;
    int rej_exp = 0;
    logic [21:0] exp_q[$];

    txsettings_ctrl dut (
        .clk(clk), .reset_n(reset_n), .trcal_in(trcal_in), .m_in(m_in),
        .dr_in(dr_in), .trext_in(trext_in), .querycomplete(querycomplete),
        .tx_busy(tx_busy), .trcal_out(trcal_out), .m_out(m_out), .dr_out(dr_out),
        .trext_out(trext_out), .settings_valid(settings_valid),
        .update_pending(update_pending), .applied(applied), .rejected(rejected),
        .update_count(update_count), .state_dbg(state_dbg)
    );

    txsettings_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .trcal_in(trcal2_in), .m_in(m_in),
        .dr_in(dr_in), .trext_in(trext_in), .querycomplete(qc2),
        .tx_busy(tx_busy), .trcal_out(trcal2_out), .m_out(m2_out), .dr_out(dr2_out),
        .trext_out(trext2_out), .settings_valid(valid2),
        .update_pending(pending2), .applied(applied2), .rejected(rejected2),
        .update_count(count2), .state_dbg(state2_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] pk(input logic [9:0] t, input logic [1:0] m,
                                       input logic d, input logic x, input logic [7:0] c);
        return {t, m, d, x, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [9:0] t, input logic [1:0] m, input logic d, input logic x);
        trcal_in = t;
        m_in = m;
        dr_in = d;
        trext_in = x;
        querycomplete = 1'b1;
        tick(1);
        querycomplete = 1'b0;
        tick(1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (applied === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_applied: got trcal=%0d with no queued expectation", trcal_out);
            end else begin
                check("applied_settings", 32'({trcal_out, m_out, dr_out, trext_out, update_count}),
                      32'(exp_q.pop_front()));
            end
        end
        if (rejected === 1'b1) begin
            checks++;
            if (rej_exp == 0) begin
                errors++;
                $display("FAIL unexpected_rejected: got pulse expected none");
            end else begin
                rej_exp--;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        trcal_in = '0;
        m_in = '0;
        dr_in = 1'b0;
        trext_in = 1'b0;
        querycomplete = 1'b0;
        tx_busy = 1'b0;
        trcal2_in = '0;
        qc2 = 1'b0;

        // reset state
        tick(3);
        @(negedge clk);
        check("rst_trcal", 32'(trcal_out), 0);
        check("rst_fields", 32'({m_out, dr_out, trext_out}), 0);
        check("rst_flags", 32'({settings_valid, update_pending, applied, rejected}), 0);
        check("rst_count", 32'(update_count), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_EMPTY));
        reset_n = 1'b1;
        tick(1);

        // first Query applies one cycle after the edge
        exp_q.push_back(pk(10'd100, M_M4, 1'b1, 1'b0, 8'd1));
        query(10'd100, M_M4, 1'b1, 1'b0);
        @(negedge clk);
        check("first_applied_latency", 32'(applied), 1);
        check("first_valid", 32'(settings_valid), 1);
        check("first_pending", 32'(update_pending), 0);
        check("first_state", 32'(state_dbg), 32'(ST_ACTIVE));

        // held off by tx_busy
        tx_busy = 1'b1;
        query(10'd200, M_M2, 1'b0, 1'b1);
        tick(2);
        @(negedge clk);
        check("busy_pending", 32'(update_pending), 1);
        check("busy_hold_trcal", 32'(trcal_out), 100);
        check("busy_state", 32'(state_dbg), 32'(ST_PENDING));
        exp_q.push_back(pk(10'd200, M_M2, 1'b0, 1'b1, 8'd2));
        tx_busy = 1'b0;
        tick(1);
        @(negedge clk);
        check("release_trcal", 32'(trcal_out), 200);
        check("release_pending", 32'(update_pending), 0);

        // two Queries while busy: latest wins, one apply
        tx_busy = 1'b1;
        query(10'd300, M_FM0, 1'b0, 1'b0);
        query(10'd400, M_M8, 1'b1, 1'b1);
        @(negedge clk);
        check("coalesce_pending", 32'(update_pending), 1);
        check("coalesce_hold_trcal", 32'(trcal_out), 200);
        exp_q.push_back(pk(10'd400, M_M8, 1'b1, 1'b1, 8'd3));
        tx_busy = 1'b0;
        tick(2);
        @(negedge clk);
        check("coalesce_count", 32'(update_count), 3);

        // out-of-range Queries are refused
        rej_exp++;
        query(10'd5, M_FM0, 1'b0, 1'b0);
        rej_exp++;
        query(10'd1001, M_FM0, 1'b0, 1'b0);
        tick(1);
        @(negedge clk);
        check("reject_trcal", 32'(trcal_out), 400);
        check("reject_count", 32'(update_count), 3);
        check("reject_state", 32'(state_dbg), 32'(ST_ACTIVE));
        check("reject_pending", 32'(update_pending), 0);

        // range boundaries are accepted
        exp_q.push_back(pk(10'd1000, M_M2, 1'b0, 1'b0, 8'd4));
        query(10'd1000, M_M2, 1'b0, 1'b0);
        exp_q.push_back(pk(10'd16, M_M4, 1'b1, 1'b1, 8'd5));
        query(10'd16, M_M4, 1'b1, 1'b1);
        tick(1);

        // level held high counts once
        exp_q.push_back(pk(10'd50, M_FM0, 1'b1, 1'b0, 8'd6));
        trcal_in = 10'd50;
        m_in = M_FM0;
        dr_in = 1'b1;
        trext_in = 1'b0;
        querycomplete = 1'b1;
        tick(10);
        querycomplete = 1'b0;
        tick(2);
        @(negedge clk);
        check("level_count", 32'(update_count), 6);

        // new Query in the apply cycle: old shadow applies, new one pends
        tx_busy = 1'b1;
        exp_q.push_back(pk(10'd120, M_M2, 1'b1, 1'b0, 8'd7));
        query(10'd120, M_M2, 1'b1, 1'b0);
        exp_q.push_back(pk(10'd130, M_M4, 1'b0, 1'b1, 8'd8));
        trcal_in = 10'd130;
        m_in = M_M4;
        dr_in = 1'b0;
        trext_in = 1'b1;
        querycomplete = 1'b1;
        tx_busy = 1'b0;
        tick(1);
        @(negedge clk);
        check("overlap_trcal", 32'(trcal_out), 120);
        check("overlap_pending", 32'(update_pending), 1);
        querycomplete = 1'b0;
        tick(1);
        @(negedge clk);
        check("overlap_final_trcal", 32'(trcal_out), 130);
        check("overlap_final_count", 32'(update_count), 8);

        // reset while pending discards the shadow
        tx_busy = 1'b1;
        query(10'd222, M_M8, 1'b0, 1'b0);
        @(negedge clk);
        check("prereset_pending", 32'(update_pending), 1);
        reset_n = 1'b0;
        tx_busy = 1'b0;
        tick(2);
        @(negedge clk);
        check("midrst_outputs", 32'({trcal_out, m_out, dr_out, trext_out}), 0);
        check("midrst_flags", 32'({settings_valid, update_pending, applied, rejected}), 0);
        check("midrst_count", 32'(update_count), 0);
        check("midrst_state", 32'(state_dbg), 32'(ST_EMPTY));
        reset_n = 1'b1;
        tick(4);
        @(negedge clk);
        check("postrst_count", 32'(update_count), 0);
        check("postrst_valid", 32'(settings_valid), 0);
        check("postrst_state", 32'(state_dbg), 32'(ST_EMPTY));

        // querycomplete held high across reset release gives one event
        reset_n = 1'b0;
        trcal_in = 10'd77;
        m_in = M_M2;
        dr_in = 1'b0;
        trext_in = 1'b1;
        querycomplete = 1'b1;
        tick(2);
        exp_q.push_back(pk(10'd77, M_M2, 1'b0, 1'b1, 8'd1));
        reset_n = 1'b1;
        tick(4);
        querycomplete = 1'b0;
        tick(2);
        @(negedge clk);
        check("held_release_count", 32'(update_count), 1);

        // narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            trcal2_in = 10'(100 + i);
            qc2 = 1'b1;
            tick(1);
            qc2 = 1'b0;
            tick(2);
        end
        @(negedge clk);
        check("sat_count", 32'(count2), 3);
        check("sat_trcal", 32'(trcal2_out), 104);

        tick(2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        check("rejects_seen", 32'(rej_exp), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/txsettings_ctrl.md
TXSETTINGS_CTRL -- requirements
Module: txsettings_ctrl

Interface
REQ-001 SHALL have parameter TRCAL_W, default 10, TRcal count width.
REQ-002 SHALL have parameter TRCAL_MIN, default 16, smallest accepted trcal_in.
REQ-003 SHALL have parameter TRCAL_MAX, default 1000, largest accepted trcal_in.
REQ-004 SHALL have parameter CNT_W, default 8, update_count width.
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 trcal_in  in  TRCAL_W  TRcal from decoded Query.
REQ-008 m_in  in  2  Miller/FM0 select from Query.
REQ-009 dr_in  in  1  divide ratio from Query.
REQ-010 trext_in  in  1  pilot-tone select from Query.
REQ-011 querycomplete  in  1  level, high once Query fields are stable.
REQ-012 tx_busy  in  1  transmitter mid-frame; settings must not change.
REQ-013 trcal_out  out  TRCAL_W; m_out  out  2; dr_out  out  1; trext_out  out  1: active settings.
REQ-014 settings_valid  out  1  active settings hold an accepted Query.
REQ-015 update_pending  out  1  shadow holds settings not yet applied.
REQ-016 applied  out  1  one-cycle pulse when active settings load.
REQ-017 rejected  out  1  one-cycle pulse when a Query is refused.
REQ-018 update_count  out  CNT_W  accepted-and-applied updates, saturating.

Function
REQ-019 SHALL detect querycomplete rising edge synchronously (registered previous value); a level held high SHALL count as one event.
REQ-020 On an edge, inputs SHALL be accepted if TRCAL_MIN <= trcal_in <= TRCAL_MAX, else rejected.
REQ-021 Accepted edge SHALL load shadow registers at that clock edge; rejected edge SHALL pulse rejected on the next cycle and leave shadow, active and state unchanged.
REQ-022 FSM states: EMPTY (no valid settings), ACTIVE (valid, nothing pending), PENDING (shadow newer than active).
REQ-023 EMPTY/ACTIVE + accepted edge -> PENDING; PENDING + accepted edge -> PENDING with shadow overwritten (latest wins).
REQ-024 PENDING with tx_busy=0 -> ACTIVE: active <= shadow, applied=1 for that cycle, update_count += 1 saturating at 2^CNT_W-1.
REQ-025 PENDING with tx_busy=1 SHALL hold; active outputs SHALL not change while tx_busy=1.
REQ-026 Minimum latency: edge seen at clock k, active outputs updated at clock k+1 (tx_busy=0).
REQ-027 Accepted edge coinciding with the apply cycle SHALL apply the old shadow and remain PENDING with the new values.
REQ-028 settings_valid SHALL be 1 in ACTIVE and in PENDING after a first apply; update_pending SHALL be 1 exactly in PENDING.

Reset
REQ-029 reset_n=0 at a clock edge SHALL set state EMPTY, all active and shadow fields 0, settings_valid/update_pending/applied/rejected 0, update_count 0, edge-detector history 0.
REQ-030 Reset mid-PENDING SHALL discard the shadow; querycomplete held high through reset release SHALL produce one edge event.

Structure
REQ-031 State encoding and M encodings (FM0, M2, M4, M8) SHALL live in shared package txsettings_pkg.
REQ-032 Range check and edge detect SHALL be inline; no sub-modules.

Verification
REQ-033 Reset, then querycomplete 0->1 with trcal=100,m=2,dr=1,trext=0, tx_busy=0 -> outputs equal inputs one cycle later, applied pulse, update_count=1, settings_valid=1.
REQ-034 tx_busy=1, accepted Query trcal=200 -> update_pending=1, outputs hold prior value; drop tx_busy -> apply next edge, update_pending=0.
REQ-035 tx_busy=1, two Queries trcal=300 then 400 -> single apply of 400, update_count +1.
REQ-036 Query trcal=5 (below TRCAL_MIN) -> rejected pulse, outputs and state unchanged, update_count unchanged.
REQ-037 querycomplete held high 10 cycles -> exactly one applied pulse; CNT_W=2 with 5 Queries -> update_count saturates at 3.
REQ-038 reset_n=0 while PENDING -> all outputs 0, state EMPTY, no applied pulse after release.
